row_encoder: RTL and testbench

Converts a sorted stream of per-nonzero row ids into CSR row-begin offsets. For rows 0..num_rows it emits r_beg[r] = count of ids < r, giving num_rows+1 offsets with r_beg[num_rows] = nnz. It sits on the write/compression side of the sparse path, turning COO row indices into the offset stream consumed by the row-offset decoding path.

---
 rtl/row_codec_pkg.sv | 11 +
 rtl/offset_packer.sv | 71 +++++++
 rtl/row_encoder.sv | 207 ++++++++++++++++++++
 tb/tb_row_encoder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_codec_pkg.sv
// Shared definitions for the row-offset encoder and decoder blocks.
package row_codec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } enc_state_t;

endpackage

// File: rtl/offset_packer.sv
// Packs one offset word per cycle into OUT_PAR lanes and owns the r_beg output register.
module offset_packer #(
  parameter int unsigned OUT_PAR  = 4,
  parameter int unsigned ID_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         push_last,
  input  logic [ID_WIDTH-1:0]          push_word,
  output logic                         can_accept,
  output logic                         r_beg_valid,
  input  logic                         r_beg_ready,
  output logic [OUT_PAR*ID_WIDTH-1:0]  r_beg_data,
  output logic [OUT_PAR-1:0]           r_beg_mask,
  output logic                         r_beg_last
);

  localparam int unsigned CNT_W = $clog2(OUT_PAR + 1);

  logic [OUT_PAR*ID_WIDTH-1:0] acc_data;
  logic [CNT_W-1:0]            acc_cnt;
  logic [OUT_PAR*ID_WIDTH-1:0] acc_next;
  logic [OUT_PAR-1:0]          fill_mask;
  logic                        acc_full;

  // Any push may complete a beat, so it is only taken when the output register is free.
  assign can_accept = !r_beg_valid || r_beg_ready;

  // Accumulator contents and lane mask as they would look after the current push.
  always_comb begin
    acc_next  = acc_data;
    fill_mask = '0;
    for (int i = 0; i < OUT_PAR; i++) begin
      if (acc_cnt == CNT_W'(i)) acc_next[i*ID_WIDTH +: ID_WIDTH] = push_word;
      fill_mask[i] = (CNT_W'(i) <= acc_cnt);
    end
    acc_full = (acc_cnt == CNT_W'(OUT_PAR - 1));
  end

  // Accumulator and output register; a drained output may be refilled in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_data    <= '0;
      acc_cnt     <= '0;
      r_beg_valid <= 1'b0;
      r_beg_data  <= '0;
      r_beg_mask  <= '0;
      r_beg_last  <= 1'b0;
    end else begin
      if (r_beg_valid && r_beg_ready) begin
        r_beg_valid <= 1'b0;
        r_beg_mask  <= '0;
        r_beg_last  <= 1'b0;
      end
      if (push && can_accept) begin
        if (acc_full || push_last) begin
          r_beg_valid <= 1'b1;
          r_beg_data  <= acc_next;
          r_beg_mask  <= fill_mask;
          r_beg_last  <= push_last;
          acc_cnt     <= '0;
        end else begin
          acc_data <= acc_next;
          acc_cnt  <= acc_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/row_encoder.sv
// Converts a sorted stream of row ids into CSR row-begin offsets.
module row_encoder
  import row_codec_pkg::*;
#(
  parameter int unsigned OFFSET   = 0,
  parameter int unsigned IN_PAR   = 2,
  parameter int unsigned OUT_PAR  = 4,
  parameter int unsigned ID_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         row_ids_valid,
  output logic                         row_ids_ready,
  input  logic [IN_PAR*ID_WIDTH-1:0]   row_ids_data,
  input  logic [IN_PAR-1:0]            row_ids_mask,
  input  logic                         row_ids_last,
  input  logic [ID_WIDTH-1:0]          num_rows,
  output logic                         r_beg_valid,
  input  logic                         r_beg_ready,
  output logic [OUT_PAR*ID_WIDTH-1:0]  r_beg_data,
  output logic [OUT_PAR-1:0]           r_beg_mask,
  output logic                         r_beg_last,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned LANE_W = $clog2(IN_PAR + 1);
  localparam int unsigned ROW_W  = ID_WIDTH + 1;

  enc_state_t                state, state_n;
  logic [IN_PAR*ID_WIDTH-1:0] in_data, in_data_n;
  logic [IN_PAR-1:0]          in_mask, in_mask_n;
  logic                       in_last, in_last_n;
  logic [LANE_W-1:0]          lane, lane_n;
  logic [ROW_W-1:0]           cur_row, cur_row_n;
  logic [ID_WIDTH-1:0]        count, count_n;
  logic [ID_WIDTH-1:0]        last_id, last_id_n;
  logic [ID_WIDTH-1:0]        num_rows_r, num_rows_r_n;
  logic                       err_q, err_n;
  logic                       busy_q, busy_n;

  logic                       ready_c;
  logic                       push, push_last;
  logic                       can_accept;
  logic                       lane_valid;
  logic [ID_WIDTH-1:0]        lane_word;
  logic [ID_WIDTH-1:0]        x;
  logic [ROW_W-1:0]           x_ext, nr_ext;

  // Select the current lane; an index of IN_PAR reads as masked off.
  always_comb begin
    lane_valid = 1'b0;
    lane_word  = '0;
    for (int i = 0; i < IN_PAR; i++) begin
      if (lane == LANE_W'(i)) begin
        lane_valid = in_mask[i];
        lane_word  = in_data[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  assign x      = lane_word - ID_WIDTH'(OFFSET);
  assign x_ext  = {1'b0, x};
  assign nr_ext = {1'b0, num_rows_r};

  // Next-state logic: one lane action per cycle, stalled whenever an emit cannot be taken.
  always_comb begin
    state_n      = state;
    in_data_n    = in_data;
    in_mask_n    = in_mask;
    in_last_n    = in_last;
    lane_n       = lane;
    cur_row_n    = cur_row;
    count_n      = count;
    last_id_n    = last_id;
    num_rows_r_n = num_rows_r;
    err_n        = err_q;
    ready_c      = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;

    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (row_ids_valid) begin
          in_data_n    = row_ids_data;
          in_mask_n    = row_ids_mask;
          in_last_n    = row_ids_last;
          lane_n       = '0;
          num_rows_r_n = num_rows;
          last_id_n    = '0;
          cur_row_n    = '0;
          count_n      = '0;
          err_n        = 1'b0;
          state_n      = RUN;
        end
      end

      RUN: begin
        if (!lane_valid) begin
          if (in_last) begin
            state_n = FLUSH;
          end else begin
            ready_c = 1'b1;
            if (row_ids_valid) begin
              in_data_n = row_ids_data;
              in_mask_n = row_ids_mask;
              in_last_n = row_ids_last;
              lane_n    = '0;
            end
          end
        end else if (x >= num_rows_r) begin
          err_n  = 1'b1;
          lane_n = lane + LANE_W'(1);
        end else if (cur_row <= x_ext) begin
          if (can_accept) begin
            push      = 1'b1;
            cur_row_n = cur_row + ROW_W'(1);
            if (x < last_id) err_n = 1'b1;
          end
        end else begin
          if (x < last_id) err_n = 1'b1;
          count_n   = count + ID_WIDTH'(1);
          last_id_n = x;
          lane_n    = lane + LANE_W'(1);
        end
      end

      FLUSH: begin
        if (cur_row <= nr_ext) begin
          if (can_accept) begin
            push      = 1'b1;
            push_last = (cur_row == nr_ext);
            cur_row_n = cur_row + ROW_W'(1);
            if (cur_row == nr_ext) state_n = DRAIN;
          end
        end else begin
          state_n = DRAIN;
        end
      end

      DRAIN: begin
        if (r_beg_valid && r_beg_ready && r_beg_last) begin
          state_n   = IDLE;
          cur_row_n = '0;
          count_n   = '0;
          last_id_n = '0;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_data    <= '0;
      in_mask    <= '0;
      in_last    <= 1'b0;
      lane       <= '0;
      cur_row    <= '0;
      count      <= '0;
      last_id    <= '0;
      num_rows_r <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      in_data    <= in_data_n;
      in_mask    <= in_mask_n;
      in_last    <= in_last_n;
      lane       <= lane_n;
      cur_row    <= cur_row_n;
      count      <= count_n;
      last_id    <= last_id_n;
      num_rows_r <= num_rows_r_n;
      err_q      <= err_n;
      busy_q     <= busy_n;
    end
  end

  assign row_ids_ready = ready_c && !rst;
  assign busy          = busy_q;
  assign err           = err_q;

  offset_packer #(
    .OUT_PAR  (OUT_PAR),
    .ID_WIDTH (ID_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_last   (push_last),
    .push_word   (count),
    .can_accept  (can_accept),
    .r_beg_valid (r_beg_valid),
    .r_beg_ready (r_beg_ready),
    .r_beg_data  (r_beg_data),
    .r_beg_mask  (r_beg_mask),
    .r_beg_last  (r_beg_last)
  );

endmodule

// File: tb/tb_row_encoder.sv
// Scoreboard bench for row_encoder: golden prefix-count model against the r_beg stream.
module tb_row_encoder;

  localparam int unsigned IW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        row_ids_valid = 1'b0;
  logic        row_ids_ready;
  logic [15:0] row_ids_data = '0;
  logic [1:0]  row_ids_mask = '0;
  logic        row_ids_last = 1'b0;
  logic [7:0]  num_rows = '0;
  logic        r_beg_valid;
  logic        r_beg_ready = 1'b1;
  logic [31:0] r_beg_data;
  logic [3:0]  r_beg_mask;
  logic        r_beg_last;
  logic        busy;
  logic        err;

  typedef struct {
    logic [7:0] v;
    bit         last;
  } exp_t;

  exp_t exp_q[$];
  int   pkt_ids[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_on   = 1'b1;
  bit   rand_ready = 1'b0;
  int   beat_cnt = 0;
  int   got_cnt  = 0;
  bit   got_last = 1'b0;
  logic [3:0] last_mask = '0;

  bit         prev_stall = 1'b0;
  logic [31:0] p_data;
  logic [3:0]  p_mask;
  logic        p_last;

  row_encoder #(
    .OFFSET   (0),
    .IN_PAR   (2),
    .OUT_PAR  (4),
    .ID_WIDTH (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .row_ids_valid (row_ids_valid),
    .row_ids_ready (row_ids_ready),
    .row_ids_data  (row_ids_data),
    .row_ids_mask  (row_ids_mask),
    .row_ids_last  (row_ids_last),
    .num_rows      (num_rows),
    .r_beg_valid   (r_beg_valid),
    .r_beg_ready   (r_beg_ready),
    .r_beg_data    (r_beg_data),
    .r_beg_mask    (r_beg_mask),
    .r_beg_last    (r_beg_last),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Output backpressure, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    r_beg_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor: stability under stall, mask shape, scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (r_beg_valid !== 1'b1 || r_beg_data !== p_data || r_beg_mask !== p_mask || r_beg_last !== p_last) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%b d=%h m=%b l=%b, need v=1 d=%h m=%b l=%b",
                   r_beg_valid, r_beg_data, r_beg_mask, r_beg_last, p_data, p_mask, p_last);
        end
      end
      prev_stall = r_beg_valid && !r_beg_ready;
      p_data = r_beg_data;
      p_mask = r_beg_mask;
      p_last = r_beg_last;

      if (r_beg_valid && r_beg_ready) begin
        bit lastflag;
        lastflag = 1'b0;
        beat_cnt++;
        last_mask = r_beg_mask;
        got_last  = r_beg_last;
        n_tests++;
        if (!(r_beg_mask inside {4'b0001, 4'b0011, 4'b0111, 4'b1111})) begin
          n_fail++;
          $display("FAIL mask_shape: got %b, need contiguous from lane 0", r_beg_mask);
        end
        for (int i = 0; i < 4; i++) begin
          if (r_beg_mask[i]) begin
            logic [7:0] w;
            w = r_beg_data[i*8 +: 8];
            got_cnt++;
            if (sb_on) begin
              n_tests++;
              if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got offset %0d, need no more output", w);
              end else begin
                exp_t e;
                e = exp_q.pop_front();
                lastflag = e.last;
                if (w !== e.v) begin
                  n_fail++;
                  $display("FAIL sb_data lane %0d: got %0d, need %0d", i, w, e.v);
                end
              end
            end
          end
        end
        if (sb_on) begin
          n_tests++;
          if (r_beg_last !== lastflag) begin
            n_fail++;
            $display("FAIL sb_last: got %b, need %b", r_beg_last, lastflag);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden model: offset r is the number of ids below r, for r = 0..nr.
  task automatic push_expected(input int nr);
    for (int r = 0; r <= nr; r++) begin
      int c;
      exp_t e;
      c = 0;
      foreach (pkt_ids[k]) if (pkt_ids[k] < r) c++;
      e.v    = 8'(c);
      e.last = (r == nr);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [1:0] m, input logic l, input logic [7:0] nr);
    int t;
    bit hs;
    t  = 0;
    hs = 1'b0;
    row_ids_valid = 1'b1;
    row_ids_data  = d;
    row_ids_mask  = m;
    row_ids_last  = l;
    num_rows      = nr;
    do begin
      @(negedge clk);
      hs = row_ids_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 1000);
    row_ids_valid = 1'b0;
    if (!hs) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got ready=0 for %0d cycles, need handshake", t);
    end
  endtask

  task automatic send_pkt(input logic [7:0] nr, input bit extra_empty);
    int n;
    n = pkt_ids.size();
    for (int k = 0; k < n; k += 2) begin
      logic [15:0] d;
      logic [1:0]  m;
      logic        l;
      d[7:0] = 8'(pkt_ids[k]);
      if (k + 1 < n) begin
        d[15:8] = 8'(pkt_ids[k+1]);
        m = 2'b11;
      end else begin
        d[15:8] = 8'hee;
        m = 2'b01;
      end
      l = (k + 2 >= n) && !extra_empty;
      send_beat(d, m, l, nr);
      if ($urandom_range(0, 3) == 0) tick();
    end
    if (n == 0 || extra_empty) send_beat(16'h0000, 2'b00, 1'b1, nr);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      tick();
      t++;
    end
    if (busy || exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=%b pending=%0d, need idle", name, busy, exp_q.size());
    end
  endtask

  task automatic clear_stats();
    beat_cnt = 0;
    got_cnt  = 0;
    got_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (r_beg_valid !== 1'b0 || r_beg_last !== 1'b0 || r_beg_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b l=%b m=%b, need 0 0 0000", r_beg_valid, r_beg_last, r_beg_mask);
    end
    n_tests++;
    if (row_ids_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, need 0", row_ids_ready);
    end
    n_tests++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b err=%b, need 0 0", busy, err);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (row_ids_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: got %b, need 1", row_ids_ready);
    end
  endtask

  task automatic test_basic();
    clear_stats();
    sb_on = 1'b1;
    pkt_ids = '{0, 0, 2, 3};
    push_expected(4);
    send_pkt(8'd4, 1'b0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b, need 1", busy);
    end
    wait_done("basic");
    n_tests++;
    if (beat_cnt != 2 || last_mask !== 4'b0001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_shape: got beats=%0d mask=%b err=%b, need 2 0001 0", beat_cnt, last_mask, err);
    end
  endtask

  task automatic test_single();
    clear_stats();
    pkt_ids = '{0};
    push_expected(3);
    send_pkt(8'd3, 1'b0);
    wait_done("single");
    n_tests++;
    if (beat_cnt != 1 || last_mask !== 4'b1111 || got_last !== 1'b1) begin
      n_fail++;
      $display("FAIL single_shape: got beats=%0d mask=%b last=%b, need 1 1111 1", beat_cnt, last_mask, got_last);
    end
  endtask

  task automatic test_empty();
    clear_stats();
    pkt_ids.delete();
    push_expected(2);
    send_pkt(8'd2, 1'b0);
    wait_done("empty");
    n_tests++;
    if (beat_cnt != 1 || last_mask !== 4'b0111 || got_last !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_shape: got beats=%0d mask=%b last=%b, need 1 0111 1", beat_cnt, last_mask, got_last);
    end
  endtask

  task automatic test_errors();
    clear_stats();
    sb_on = 1'b1;
    pkt_ids = '{5};
    push_expected(4);
    send_pkt(8'd4, 1'b0);
    wait_done("err_range");
    n_tests++;
    if (err !== 1'b1 || got_cnt != 5) begin
      n_fail++;
      $display("FAIL err_range: got err=%b count=%0d, need 1 5", err, got_cnt);
    end
    clear_stats();
    sb_on = 1'b0;
    pkt_ids = '{2, 1};
    send_pkt(8'd4, 1'b0);
    wait_done("err_order");
    n_tests++;
    if (err !== 1'b1 || got_cnt != 5 || got_last !== 1'b1) begin
      n_fail++;
      $display("FAIL err_order: got err=%b count=%0d last=%b, need 1 5 1", err, got_cnt, got_last);
    end
    sb_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    clear_stats();
    sb_on = 1'b0;
    send_beat(16'h0100, 2'b11, 1'b0, 8'd8);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    n_tests++;
    if (r_beg_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: got v=%b busy=%b err=%b, need 0 0 0", r_beg_valid, busy, err);
    end
    rst = 1'b0;
    tick();
    clear_stats();
    sb_on = 1'b1;
    pkt_ids = '{1, 1, 3};
    push_expected(5);
    send_pkt(8'd5, 1'b0);
    wait_done("midrst");
    n_tests++;
    if (beat_cnt != 2 || got_cnt != 6 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_shape: got beats=%0d count=%0d err=%b, need 2 6 0", beat_cnt, got_cnt, err);
    end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    sb_on = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int nr;
      int nnz;
      bit extra;
      nr  = $urandom_range(0, 8);
      nnz = (nr == 0) ? 0 : $urandom_range(0, 8);
      pkt_ids.delete();
      for (int k = 0; k < nnz; k++) pkt_ids.push_back($urandom_range(0, nr - 1));
      pkt_ids.sort();
      extra = ($urandom_range(0, 3) == 0);
      clear_stats();
      push_expected(nr);
      send_pkt(8'(nr), extra);
      wait_done("random");
      n_tests++;
      if (got_cnt != nr + 1 || err !== 1'b0 || got_last !== 1'b1) begin
        n_fail++;
        $display("FAIL random_pkt %0d: got count=%0d err=%b last=%b, need %0d 0 1", p, got_cnt, err, got_last, nr + 1);
      end
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_empty();
    test_errors();
    test_reset_mid();
    test_random();
    repeat (3) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
